// File: rtl/poly_mem_ctrl_if.sv
// Bus bundle for poly_mem_ctrl: host command, load/unload coefficient streams
// and the NTT core memory port. "slave" is the controller side.
interface poly_mem_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_base;
  logic [7:0]  cmd_len;

  logic [11:0] in_coef;
  logic        in_valid;
  logic        in_ready;

  logic [11:0] out_coef;
  logic        out_valid;
  logic        out_ready;

  logic        core_start;
  logic        core_done;
  logic [7:0]  core_r_addr;
  logic [95:0] core_r_data;
  logic [7:0]  core_w_addr;
  logic [95:0] core_w_data;
  logic        core_w_en;

  logic        busy;
  logic        coef_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_len,
    input  in_coef, in_valid, out_ready,
    input  core_done, core_r_addr, core_w_addr, core_w_data, core_w_en,
    output cmd_ready, in_ready, out_coef, out_valid,
    output core_start, core_r_data, busy, coef_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_len,
    output in_coef, in_valid, out_ready,
    output core_done, core_r_addr, core_w_addr, core_w_data, core_w_en,
    input  cmd_ready, in_ready, out_coef, out_valid,
    input  core_start, core_r_data, busy, coef_err
  );
endinterface

// File: rtl/poly_mem_ctrl.sv
// Polynomial memory controller: 256 x 96-bit coefficient RAM with host load/unload
// streams and NTT core port. Optional range check enabled by POLY_MEM_COEF_CHECK_EN.
module poly_mem_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  poly_mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StUnload, StCore} state_e;

  state_e      state_q;
  logic [7:0]  base_q;
  logic [8:0]  len_q;
  logic [8:0]  word_q;
  logic [2:0]  idx_q;
  logic [83:0] pack_q;
  logic [95:0] shift_q;
  logic [95:0] rd_data_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        core_start_q;

  logic [95:0] mem [256];

  logic        cmd_fire;
  logic        in_fire;
  logic        out_fire;
  logic        last_word;
  logic [7:0]  word_addr;
  logic [7:0]  rd_addr;
  logic [95:0] rd_word;
  logic        ld_we;
  logic        core_we;
  logic        mem_we;
  logic [7:0]  wr_addr;
  logic [95:0] wr_data;

  always_comb begin
    cmd_fire  = bus.cmd_valid && (state_q == StIdle);
    in_fire   = (state_q == StLoad) && bus.in_valid && in_ready_q;
    out_fire  = (state_q == StUnload) && out_valid_q && bus.out_ready;
    last_word = (word_q == (len_q - 9'd1));
    word_addr = base_q + word_q[7:0];
    rd_addr   = (state_q == StCore) ? bus.core_r_addr : word_addr;
    rd_word   = mem[rd_addr];
    ld_we     = in_fire && (idx_q == 3'd7);
    core_we   = (state_q == StCore) && bus.core_w_en;
    mem_we    = ld_we || core_we;
    wr_addr   = core_we ? bus.core_w_addr : word_addr;
    wr_data   = core_we ? bus.core_w_data : {bus.in_coef, pack_q};
  end

  // Nonblocking write gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      base_q       <= '0;
      len_q        <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      pack_q       <= '0;
      shift_q      <= '0;
      rd_data_q    <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      rd_data_q    <= rd_word;
      unique case (state_q)
        StIdle: begin
          if (cmd_fire) begin
            base_q <= bus.cmd_base;
            len_q  <= (bus.cmd_len == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len};
            word_q <= '0;
            idx_q  <= '0;
            unique case (bus.cmd_op)
              2'd0: begin
                state_q    <= StLoad;
                in_ready_q <= 1'b1;
              end
              2'd1: begin
                state_q     <= StUnload;
                out_valid_q <= 1'b0;
              end
              2'd2: begin
                state_q      <= StCore;
                core_start_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        StLoad: begin
          if (in_fire) begin
            // Shift in from the top so coefficient 0 ends up in bits [11:0].
            pack_q <= {bus.in_coef, pack_q[83:12]};
            idx_q  <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              if (last_word) begin
                state_q    <= StIdle;
                in_ready_q <= 1'b0;
              end else begin
                word_q <= word_q + 9'd1;
              end
            end
          end
        end
        StUnload: begin
          if (!out_valid_q) begin
            shift_q     <= rd_word;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
          end else if (out_fire) begin
            shift_q <= {12'd0, shift_q[95:12]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              out_valid_q <= 1'b0;
              if (last_word) begin
                state_q <= StIdle;
              end else begin
                word_q <= word_q + 9'd1;
              end
            end
          end
        end
        StCore: begin
          if (bus.core_done) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

`ifdef POLY_MEM_COEF_CHECK_EN
  localparam logic [11:0] CoefQ = 12'd3329;

  logic coef_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_err_q <= 1'b0;
    end else if (cmd_fire && (bus.cmd_op == 2'd0)) begin
      coef_err_q <= 1'b0;
    end else if (in_fire && (bus.in_coef >= CoefQ)) begin
      coef_err_q <= 1'b1;
    end
  end

  assign bus.coef_err = coef_err_q;
`else
  assign bus.coef_err = 1'b0;
`endif

  assign bus.cmd_ready   = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_coef    = shift_q[11:0];
  assign bus.core_start  = core_start_q;
  assign bus.core_r_data = rd_data_q;

endmodule

// File: tb/tb_poly_mem_ctrl.sv
// Directed self-checking bench for poly_mem_ctrl; expected RAM contents are kept
// in a small word model filled from the coefficients the bench itself loads.
module tb_poly_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  poly_mem_ctrl_if bus ();

  poly_mem_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef POLY_MEM_COEF_CHECK_EN
  localparam bit ErrExp = 1'b1;
`else
  localparam bit ErrExp = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [95:0] model [256];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] base, input logic [7:0] len);
    int wt = 0;
    while (!bus.cmd_ready && wt < 200) begin
      @(posedge clk); #1;
      wt++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [7:0] base, input logic [11:0] coefs[$]);
    int stalls = 0;
    logic [95:0] w;
    logic [7:0] a;
    for (int i = 0; i < coefs.size(); i++) begin
      int wt = 0;
      bus.in_valid = 1'b1;
      bus.in_coef  = coefs[i];
      while (!bus.in_ready && wt < 20) begin
        @(posedge clk); #1;
        wt++;
        stalls++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("load_bubbles", stalls, 0);
    for (int k = 0; k < coefs.size() / 8; k++) begin
      w = '0;
      for (int i = 0; i < 8; i++) w[12*i +: 12] = coefs[8*k + i];
      a = base + 8'(k);
      model[a] = w;
    end
  endtask

  task automatic load(input logic [7:0] base, input logic [7:0] len, input logic [11:0] coefs[$]);
    send_cmd(2'd0, base, len);
    feed(base, coefs);
  endtask

  task automatic unload(input logic [7:0] base, input logic [7:0] len, input bit toggle);
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [11:0] prev_coef = '0;
    logic [7:0] a;
    int cyc = 0, gaps = 0, holdbad = 0, lenw, n;
    bit seen = 1'b0, prev_stall = 1'b0;
    lenw = (len == 8'd0) ? 256 : int'(len);
    n = lenw * 8;
    for (int w = 0; w < lenw; w++) begin
      a = base + 8'(w);
      for (int i = 0; i < 8; i++) exp_q.push_back(model[a][12*i +: 12]);
    end
    send_cmd(2'd1, base, len);
    while (got_q.size() < n && cyc < n * 4 + 100) begin
      bus.out_ready = toggle ? cyc[0] : 1'b1;
      if (prev_stall && !(bus.out_valid && bus.out_coef == prev_coef)) holdbad++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_coef  = bus.out_coef;
      if (bus.out_valid) seen = 1'b1;
      else if (seen) gaps++;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_coef);
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("unload_count", got_q.size(), n);
    for (int i = 0; i < got_q.size(); i++)
      check($sformatf("unload_coef%0d", i), got_q[i], exp_q[i]);
    check("unload_hold", holdbad, 0);
    if (!toggle) check("unload_gaps", gaps, lenw - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] cq[$];
    logic [95:0] new_word = 96'h123456789ABCDEF012345678;

    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_base = 0; bus.cmd_len = 0;
    bus.in_coef = 0; bus.in_valid = 0; bus.out_ready = 0;
    bus.core_done = 0; bus.core_r_addr = 0; bus.core_w_addr = 0;
    bus.core_w_data = 0; bus.core_w_en = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_coef", bus.out_coef, 12'd0);
    check("rst_core_start", bus.core_start, 1'b0);
    check("rst_core_r_data", bus.core_r_data, 96'd0);
    check("rst_coef_err", bus.coef_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full polynomial round trip
    cq.delete();
    for (int i = 0; i < 256; i++) cq.push_back(12'(i));
    load(8'h10, 8'd32, cq);
    unload(8'h10, 8'd32, 1'b0);

    // Address wrap
    cq.delete();
    for (int i = 0; i < 16; i++) cq.push_back(12'(i * 100 + 7));
    load(8'hFF, 8'd2, cq);
    unload(8'hFF, 8'd2, 1'b0);

    // Reserved op stays idle
    send_cmd(2'd3, 8'h00, 8'h00);
    check("op3_busy", bus.busy, 1'b0);
    check("op3_cmd_ready", bus.cmd_ready, 1'b1);

    // Core port
    cq.delete();
    for (int i = 0; i < 24; i++) cq.push_back(12'(1000 + i * 37));
    load(8'h05, 8'd3, cq);
    bus.core_w_en = 1'b1; bus.core_w_addr = 8'h05; bus.core_w_data = 96'hDEAD;
    bus.core_done = 1'b1;
    @(posedge clk); #1;
    bus.core_w_en = 1'b0; bus.core_done = 1'b0;
    check("idle_done_ignored", bus.cmd_ready, 1'b1);
    send_cmd(2'd2, 8'h00, 8'h00);
    check("core_start_pulse", bus.core_start, 1'b1);
    check("core_busy", bus.busy, 1'b1);
    bus.core_r_addr = 8'h05;
    @(posedge clk); #1;
    check("core_start_low", bus.core_start, 1'b0);
    check("core_rd_05", bus.core_r_data, model[8'h05]);
    bus.core_r_addr = 8'h07; bus.core_w_addr = 8'h07;
    bus.core_w_data = new_word; bus.core_w_en = 1'b1;
    @(posedge clk); #1;
    bus.core_w_en = 1'b0;
    check("core_rd_07_old", bus.core_r_data, model[8'h07]);
    model[8'h07] = new_word;
    @(posedge clk); #1;
    check("core_rd_07_new", bus.core_r_data, new_word);
    check("core_still_busy", bus.busy, 1'b1);
    bus.core_done = 1'b1;
    @(posedge clk); #1;
    bus.core_done = 1'b0;
    check("core_done_busy", bus.busy, 1'b0);
    check("core_done_ready", bus.cmd_ready, 1'b1);

    // Stalled unload
    unload(8'h05, 8'd3, 1'b1);

    // Reset during load: partial word discarded, old contents kept
    send_cmd(2'd0, 8'h20, 8'd1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_coef  = 12'(12'h700 + i);
      @(posedge clk); #1;
    end
    bus.in_coef = 12'h704;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_cmd_ready", bus.cmd_ready, 1'b1);
    check("midrst_core_r_data", bus.core_r_data, 96'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    unload(8'h20, 8'd1, 1'b0);

    // Coefficient range flag
    cq.delete();
    cq = '{12'd1, 12'd2, 12'd3329, 12'd4, 12'd5, 12'd6, 12'd7, 12'd3328};
    load(8'h40, 8'd1, cq);
    check("coef_err_set", bus.coef_err, ErrExp);
    unload(8'h40, 8'd1, 1'b0);
    check("coef_err_sticky", bus.coef_err, ErrExp);
    send_cmd(2'd0, 8'h41, 8'd1);
    check("coef_err_clear", bus.coef_err, 1'b0);
    cq.delete();
    for (int i = 0; i < 8; i++) cq.push_back(12'(i + 50));
    feed(8'h41, cq);
    check("coef_err_stays_clear", bus.coef_err, 1'b0);
    unload(8'h41, 8'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
